// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O block: region decode, register
// word offsets, flag bit positions and the READY/OVR update rule.
package io_pkg;

    // Region 0xF000-0xF01F: ADDR[15:5] must equal this.
    localparam logic [10:0] IO_BASE = 11'h780;
    // Read value for unmapped offsets inside the region.
    localparam logic [15:0] IO_DEAD = 16'hDEAD;

    // Word offsets (ADDR[4:1]).
    localparam logic [3:0] IO_HEX  = 4'h0;
    localparam logic [3:0] IO_LEDR = 4'h1;
    localparam logic [3:0] IO_LEDG = 4'h2;
    localparam logic [3:0] IO_KEYS = 4'h3;
    localparam logic [3:0] IO_KCTL = 4'h4;
    localparam logic [3:0] IO_SWS  = 4'h5;
    localparam logic [3:0] IO_TCNT = 4'h6;
    localparam logic [3:0] IO_TLIM = 4'h7;
    localparam logic [3:0] IO_TCTL = 4'h8;

    // Bit positions inside KCTL / TCTL.
    localparam int FLG_READY = 0;
    localparam int FLG_OVR   = 1;

    // READY/OVR next state. Writing 0 clears a bit, writing 1 does nothing.
    // An event always sets READY (beats a clear); OVR is set only when the
    // event finds READY already set and not being cleared this cycle.
    function automatic logic [1:0] flag_next(
        input logic [1:0] cur,
        input logic       evt,
        input logic       wr,
        input logic [1:0] wdata
    );
        logic [1:0] nxt;
        logic       clr_rdy;
        logic       clr_ovr;
        clr_rdy = wr && !wdata[FLG_READY];
        clr_ovr = wr && !wdata[FLG_OVR];
        nxt     = cur;
        if (clr_ovr)
            nxt[FLG_OVR] = 1'b0;
        if (evt && cur[FLG_READY] && !clr_rdy)
            nxt[FLG_OVR] = 1'b1;
        if (clr_rdy)
            nxt[FLG_READY] = 1'b0;
        if (evt)
            nxt[FLG_READY] = 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/io_ctrl_if.sv
// CPU data-memory port as seen by the I/O block.
interface io_ctrl_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] din;
    logic             we;
    logic [DBITS-1:0] dout;
    logic             sel;

    modport master (output addr, output din, output we, input dout, input sel);
    modport slave  (input addr, input din, input we, output dout, output sel);
endinterface

// File: rtl/debounce.sv
// Two-flop synchroniser plus one shared stability counter for a whole input
// group. The debounced vector only moves after the synchronised vector has
// held a new value for DEBOUNCE consecutive cycles.
module debounce #(
    parameter int             W        = 4,
    parameter int             DEBOUNCE = 500000,
    parameter logic [W-1:0]   INIT     = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic [W-1:0] next_val,
    output logic         load
);

    localparam int CW = $clog2(DEBOUNCE);

    logic [W-1:0]  sync1_reg;
    logic [W-1:0]  sync2_reg;
    logic [W-1:0]  deb_reg;
    logic [CW-1:0] cnt_reg;
    logic          hold;

    // "Changing" means the synchronised vector will differ on the next edge;
    // nothing to count when it already matches the debounced value.
    assign hold     = (sync1_reg != sync2_reg) || (sync2_reg == deb_reg);
    assign load     = !hold && (cnt_reg == CW'(DEBOUNCE - 1));
    assign stable   = deb_reg;
    assign next_val = sync2_reg;

    // Synchronise, count stable cycles, copy to the debounced vector at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= INIT;
            sync2_reg <= INIT;
            deb_reg   <= INIT;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (hold) begin
                cnt_reg <= '0;
            end else if (load) begin
                cnt_reg <= '0;
                deb_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg.sv
// 4-bit to 7-segment hex decoder, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
module seven_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup of the hex glyph for one nibble.
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O register block: display/LED outputs, debounced keys and
// switches with a key-event flag, and a prescaled tick counter with limit.
module io_ctrl
    import io_pkg::*;
#(
    parameter int DBITS    = 16,
    parameter int DEBOUNCE = 500000,
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst,
    io_ctrl_if.slave   bus,
    input  logic [3:0] key,
    input  logic [9:0] sw,
    output logic [9:0] ledr,
    output logic [7:0] ledg,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam int PW = $clog2(PRESCALE);

    logic [15:0]   hex_reg;
    logic [9:0]    ledr_reg;
    logic [7:0]    ledg_reg;
    logic [1:0]    kctl_reg;
    logic [15:0]   tcnt_reg;
    logic [15:0]   tlim_reg;
    logic [1:0]    tctl_reg;
    logic [PW-1:0] presc_reg;

    logic [3:0]  word;
    logic        sel;
    logic        wr;
    logic        wr_hex, wr_ledr, wr_ledg, wr_kctl, wr_tcnt, wr_tlim, wr_tctl;
    logic [15:0] rdata;

    logic [3:0]  key_deb;
    logic [3:0]  key_sync;
    logic        key_load;
    logic        key_event;
    logic [9:0]  sw_deb;
    logic [9:0]  unused_sw_next;
    logic        unused_sw_load;
    logic        unused_addr0;

    logic        tick;
    logic [15:0] tcnt_inc;
    logic        lim_hit;
    logic        t_event;

    logic [6:0]  seg [4];

    // Address decode; bit 0 is a byte select and plays no part.
    assign word         = bus.addr[4:1];
    assign sel          = (bus.addr[15:5] == IO_BASE);
    assign wr           = bus.we && sel;
    assign wr_hex       = wr && (word == IO_HEX);
    assign wr_ledr      = wr && (word == IO_LEDR);
    assign wr_ledg      = wr && (word == IO_LEDG);
    assign wr_kctl      = wr && (word == IO_KCTL);
    assign wr_tcnt      = wr && (word == IO_TCNT);
    assign wr_tlim      = wr && (word == IO_TLIM);
    assign wr_tctl      = wr && (word == IO_TCTL);
    assign unused_addr0 = bus.addr[0];

    // Keys are active-low at the pin, so the synchronisers start at all-ones.
    debounce #(.W(4), .DEBOUNCE(DEBOUNCE), .INIT(4'b1111)) u_key_db (
        .clk      (clk),
        .rst      (rst),
        .raw      (key),
        .stable   (key_deb),
        .next_val (key_sync),
        .load     (key_load)
    );

    debounce #(.W(10), .DEBOUNCE(DEBOUNCE), .INIT(10'd0)) u_sw_db (
        .clk      (clk),
        .rst      (rst),
        .raw      (sw),
        .stable   (sw_deb),
        .next_val (unused_sw_next),
        .load     (unused_sw_load)
    );

    // A press is a pin going 1->0 in the debounced vector on the load edge.
    assign key_event = key_load && |(key_deb & ~key_sync);

    assign tick     = (presc_reg == PW'(PRESCALE - 1));
    assign tcnt_inc = tcnt_reg + 16'd1;
    assign lim_hit  = (tlim_reg != 16'd0) && (tcnt_inc == tlim_reg);
    // A CPU load of TCNT on the same edge swallows the tick and its wrap.
    assign t_event  = tick && lim_hit && !wr_tcnt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_seg
            seven_seg u_seg (
                .nib (hex_reg[4*gi +: 4]),
                .seg (seg[gi])
            );
        end
    endgenerate

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign ledr = ledr_reg;
    assign ledg = ledg_reg;

    // CPU-written registers and the two event-flag pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
            tlim_reg <= '0;
            kctl_reg <= '0;
            tctl_reg <= '0;
        end else begin
            if (wr_hex)
                hex_reg <= bus.din[15:0];
            if (wr_ledr)
                ledr_reg <= bus.din[9:0];
            if (wr_ledg)
                ledg_reg <= bus.din[7:0];
            if (wr_tlim)
                tlim_reg <= bus.din[15:0];
            kctl_reg <= flag_next(kctl_reg, key_event, wr_kctl, bus.din[1:0]);
            tctl_reg <= flag_next(tctl_reg, t_event, wr_tctl, bus.din[1:0]);
        end
    end

    // Prescaler and tick counter; a TCNT write reloads and restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            tcnt_reg  <= '0;
        end else if (wr_tcnt) begin
            presc_reg <= '0;
            tcnt_reg  <= bus.din[15:0];
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick)
                tcnt_reg <= lim_hit ? 16'd0 : tcnt_inc;
        end
    end

    // Zero-latency read mux over current register state.
    always_comb begin
        rdata = IO_DEAD;
        case (word)
            IO_HEX:  rdata = hex_reg;
            IO_LEDR: rdata = {6'd0, ledr_reg};
            IO_LEDG: rdata = {8'd0, ledg_reg};
            IO_KEYS: rdata = {12'd0, ~key_deb};
            IO_KCTL: rdata = {14'd0, kctl_reg};
            IO_SWS:  rdata = {6'd0, sw_deb};
            IO_TCNT: rdata = tcnt_reg;
            IO_TLIM: rdata = tlim_reg;
            IO_TCTL: rdata = {14'd0, tctl_reg};
            default: rdata = IO_DEAD;
        endcase
    end

    assign bus.sel  = sel;
    assign bus.dout = sel ? DBITS'(rdata) : '0;

endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl with DEBOUNCE=4, PRESCALE=3. Inputs change and reads happen
// in the low half of the clock; each read pushes its expectation to a queue and
// pops it once DOUT has settled.
module tb_io_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [7:0] ledg;
    logic [6:0] hex0, hex1, hex2, hex3;

    io_ctrl_if #(.DBITS(16)) bus ();

    io_ctrl #(.DBITS(16), .DEBOUNCE(4), .PRESCALE(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .key  (key),
        .sw   (sw),
        .ledr (ledr),
        .ledg (ledg),
        .hex0 (hex0),
        .hex1 (hex1),
        .hex2 (hex2),
        .hex3 (hex3)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] dout;
        logic        sel;
        logic        chk_dout;
        string       name;
    } vec_t;

    exp_t sb_q[$];
    vec_t rst_tab[12];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] tcnt_seq [6];
    logic [15:0] tctl_seq [6];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] e);
        n_cmp++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic rd(input logic [15:0] a, input string nm, input logic [15:0] e);
        exp_t t;
        bus.addr = a;
        t.name = nm;
        t.exp  = e;
        sb_q.push_back(t);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: queue empty at read of %h", a);
        end else begin
            t = sb_q.pop_front();
            chk(t.name, bus.dout, t.exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.we   = 1'b0;
        $display("wr   %h <= %h", a, d);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_rst_tab(input string tag);
        for (int i = 0; i < 12; i++) begin
            bus.addr = rst_tab[i].addr;
            #1;
            chk({tag, "_sel_", rst_tab[i].name}, {15'd0, bus.sel}, {15'd0, rst_tab[i].sel});
            if (rst_tab[i].chk_dout)
                rd(rst_tab[i].addr, {tag, "_", rst_tab[i].name}, rst_tab[i].dout);
        end
        chk({tag, "_hex0"}, {9'd0, hex0}, 16'h0040);
        chk({tag, "_hex1"}, {9'd0, hex1}, 16'h0040);
        chk({tag, "_hex2"}, {9'd0, hex2}, 16'h0040);
        chk({tag, "_hex3"}, {9'd0, hex3}, 16'h0040);
        chk({tag, "_ledr"}, {6'd0, ledr}, 16'h0000);
        chk({tag, "_ledg"}, {8'd0, ledg}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_tab[0]  = '{16'hF000, 16'h0000, 1'b1, 1'b1, "HEX"};
        rst_tab[1]  = '{16'hF002, 16'h0000, 1'b1, 1'b1, "LEDR"};
        rst_tab[2]  = '{16'hF004, 16'h0000, 1'b1, 1'b1, "LEDG"};
        rst_tab[3]  = '{16'hF006, 16'h0000, 1'b1, 1'b1, "KEYS"};
        rst_tab[4]  = '{16'hF008, 16'h0000, 1'b1, 1'b1, "KCTL"};
        rst_tab[5]  = '{16'hF00A, 16'h0000, 1'b1, 1'b1, "SWS"};
        rst_tab[6]  = '{16'hF00C, 16'h0000, 1'b1, 1'b1, "TCNT"};
        rst_tab[7]  = '{16'hF00E, 16'h0000, 1'b1, 1'b1, "TLIM"};
        rst_tab[8]  = '{16'hF010, 16'h0000, 1'b1, 1'b1, "TCTL"};
        rst_tab[9]  = '{16'hF012, 16'hDEAD, 1'b1, 1'b1, "UNMAP12"};
        rst_tab[10] = '{16'hF01F, 16'hDEAD, 1'b1, 1'b1, "UNMAP1E"};
        rst_tab[11] = '{16'h0200, 16'h0000, 1'b0, 1'b0, "OUTSIDE"};

        tcnt_seq = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0};
        tctl_seq = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};

        rst      = 1'b1;
        key      = 4'b1111;
        sw       = 10'd0;
        bus.addr = 16'h0000;
        bus.din  = 16'h0000;
        bus.we   = 1'b0;
        cyc(3);
        rst = 1'b0;

        // Reset state, read before any edge after release.
        apply_rst_tab("rst");

        // Display and LED registers.
        wr(16'hF000, 16'h12AF);
        chk("hex0_F", {9'd0, hex0}, {9'd0, 7'b0001110});
        chk("hex1_A", {9'd0, hex1}, {9'd0, 7'b0001000});
        chk("hex2_2", {9'd0, hex2}, {9'd0, 7'b0100100});
        chk("hex3_1", {9'd0, hex3}, {9'd0, 7'b1111001});
        rd(16'hF000, "HEX_rb", 16'h12AF);
        wr(16'hF002, 16'hFFFF);
        chk("ledr_pins", {6'd0, ledr}, 16'h03FF);
        rd(16'hF002, "LEDR_rb", 16'h03FF);
        wr(16'hF005, 16'h01A5);
        chk("ledg_pins", {8'd0, ledg}, 16'h00A5);
        rd(16'hF004, "LEDG_rb", 16'h00A5);
        wr(16'hF012, 16'h1234);
        rd(16'hF012, "UNMAP_wr", 16'hDEAD);

        // KEY[0] press and a switch pattern: visible exactly on the 6th edge.
        key = 4'b1110;
        sw  = 10'h2A5;
        cyc(5);
        rd(16'hF006, "KEYS_early", 16'h0000);
        rd(16'hF00A, "SWS_early", 16'h0000);
        rd(16'hF008, "KCTL_early", 16'h0000);
        cyc(1);
        rd(16'hF006, "KEYS_press0", 16'h0001);
        rd(16'hF008, "KCTL_press0", 16'h0001);
        rd(16'hF00A, "SWS_set", 16'h02A5);

        // 2-cycle glitch on KEY[1] must never reach KEYS.
        key = 4'b1100;
        cyc(2);
        key = 4'b1110;
        cyc(10);
        rd(16'hF006, "KEYS_glitch", 16'h0001);
        rd(16'hF008, "KCTL_glitch", 16'h0001);

        // Second press while READY=1 raises OVR.
        key = 4'b1010;
        cyc(6);
        rd(16'hF006, "KEYS_press2", 16'h0005);
        rd(16'hF008, "KCTL_ovr", 16'h0003);

        // CPU clears both flags on the very edge a new press lands.
        key = 4'b0010;
        cyc(5);
        wr(16'hF008, 16'h0000);
        rd(16'hF006, "KEYS_press3", 16'h000D);
        rd(16'hF008, "KCTL_setwins", 16'h0001);
        wr(16'hF008, 16'h0000);
        rd(16'hF008, "KCTL_clear", 16'h0000);
        wr(16'hF008, 16'h0003);
        rd(16'hF008, "KCTL_wr1", 16'h0000);

        // Timer with TLIM=2, aligned by a TCNT load.
        wr(16'hF00E, 16'h0002);
        wr(16'hF00C, 16'h0000);
        rd(16'hF00C, "TCNT_load0", 16'h0000);
        rd(16'hF00E, "TLIM_rb", 16'h0002);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            rd(16'hF00C, $sformatf("TCNT_step%0d", i + 1), tcnt_seq[i]);
            rd(16'hF010, $sformatf("TCTL_step%0d", i + 1), tctl_seq[i]);
        end
        // Load TCNT on a tick edge: no increment, then +1 three edges later.
        cyc(2);
        wr(16'hF00C, 16'h0005);
        rd(16'hF00C, "TCNT_wr_tick", 16'h0005);
        cyc(2);
        rd(16'hF00C, "TCNT_hold", 16'h0005);
        cyc(1);
        rd(16'hF00C, "TCNT_inc", 16'h0006);
        rd(16'hF010, "TCTL_keep", 16'h0001);

        // Asynchronous reset in mid-debounce with TCNT=7.
        wr(16'hF00C, 16'h0007);
        rd(16'hF00C, "TCNT_seven", 16'h0007);
        key = 4'b1111;
        sw  = 10'd0;
        cyc(2);
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        apply_rst_tab("arst");
        @(negedge clk);
        rst = 1'b0;
        cyc(8);
        rd(16'hF006, "KEYS_after_rst", 16'h0000);
        rd(16'hF008, "KCTL_after_rst", 16'h0000);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
